// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write arbiter and its queue.
package regfile_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // reg_idx stands in for the destination field; "reg" is a reserved word.
  typedef struct packed {
    logic        valid;
    logic [4:0]  reg_idx;
    logic [31:0] data;
  } wq_entry_t;

  typedef enum logic {
    NORMAL,
    STARVED
  } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Request, lookup and register-file write signals of the write arbiter.
interface regfile_write_arbiter_if #(
  parameter int unsigned DEPTH = 4
);
  logic                         wb_we;
  logic [4:0]                   wb_reg;
  logic [31:0]                  wb_data;
  logic                         jal_valid;
  logic [31:0]                  jal_addr;
  logic                         mdu_valid;
  logic                         mdu_ready;
  logic [4:0]                   mdu_reg;
  logic [31:0]                  mdu_data;
  logic [4:0]                   rd_reg1;
  logic [4:0]                   rd_reg2;
  logic                         rd_pending1;
  logic                         rd_pending2;
  logic                         stall;
  logic                         rf_we;
  logic [4:0]                   rf_waddr;
  logic [31:0]                  rf_wdata;
  logic [$clog2(DEPTH+1)-1:0]   q_count;

  modport master (
    output wb_we, wb_reg, wb_data, jal_valid, jal_addr,
    output mdu_valid, mdu_reg, mdu_data, rd_reg1, rd_reg2,
    input  mdu_ready, rd_pending1, rd_pending2, stall,
    input  rf_we, rf_waddr, rf_wdata, q_count
  );

  modport slave (
    input  wb_we, wb_reg, wb_data, jal_valid, jal_addr,
    input  mdu_valid, mdu_reg, mdu_data, rd_reg1, rd_reg2,
    output mdu_ready, rd_pending1, rd_pending2, stall,
    output rf_we, rf_waddr, rf_wdata, q_count
  );

endinterface

// File: rtl/regfile_wq.sv
// Circular write queue: two ordered pushes and one pop per cycle, cancel-by-register,
// and parallel destination match for pending lookups.
module regfile_wq
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push0,
  input  wq_entry_t                  push0_entry,
  input  logic                       push1,
  input  wq_entry_t                  push1_entry,
  input  logic                       pop,
  input  logic                       cancel,
  input  logic [4:0]                 cancel_reg,
  input  logic [4:0]                 look_reg1,
  input  logic [4:0]                 look_reg2,
  output logic                       hit1,
  output logic                       hit2,
  output wq_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wq_entry_t        mem_q [DEPTH];
  wq_entry_t        mem_d [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, tail1;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d  = mem_q;
    live_d = live_q;
    head_d = head_q;
    // Cancel sees only entries resident before this edge; pushes below overwrite later.
    for (int i = 0; i < DEPTH; i++) begin
      if (cancel && live_q[i] && mem_q[i].reg_idx == cancel_reg) begin
        mem_d[i].valid = 1'b0;
      end
    end
    if (pop) begin
      live_d[head_q] = 1'b0;
      head_d         = wrap_inc(head_q);
    end
    tail1 = push0 ? wrap_inc(tail_q) : tail_q;
    if (push0) begin
      mem_d[tail_q]  = push0_entry;
      live_d[tail_q] = 1'b1;
    end
    if (push1) begin
      mem_d[tail1]  = push1_entry;
      live_d[tail1] = 1'b1;
    end
    tail_d  = push1 ? wrap_inc(tail1) : tail1;
    count_d = count_q + CW'(push0) + CW'(push1) - CW'(pop);
  end

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && mem_q[i].valid && mem_q[i].reg_idx == look_reg1) hit1 = 1'b1;
      if (live_q[i] && mem_q[i].valid && mem_q[i].reg_idx == look_reg2) hit2 = 1'b1;
    end
  end

  assign head  = mem_q[head_q];
  assign count = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      live_q  <= live_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: WB has priority, JAL/MDU writes queue in order and
// drain on free cycles, with a starvation stall when the queue head keeps losing.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          rf_we_q;
  logic [4:0]    rf_waddr_q;
  logic [31:0]   rf_wdata_q;

  logic          wb_sel, jal_acc, mdu_rdy, mdu_push, pop, stall_c;
  logic          hit1, hit2;
  wq_entry_t     head, jal_entry, mdu_entry;
  logic [CW-1:0] q_cnt;

  always_comb begin
    wb_sel    = bus.wb_we && (bus.wb_reg != REG_ZERO);
    stall_c   = !reset && (state_q == STARVED || q_cnt == CW'(DEPTH));
    jal_acc   = !reset && bus.jal_valid && !stall_c;
    // Capacity is judged on the pre-pop count, so a slot freed this cycle is not reused.
    mdu_rdy   = !reset && ((32'(q_cnt) + 32'(jal_acc)) < DEPTH);
    mdu_push  = mdu_rdy && bus.mdu_valid && (bus.mdu_reg != REG_ZERO);
    pop       = !reset && !wb_sel && (q_cnt != '0);
    jal_entry = '{valid: 1'b1, reg_idx: REG_RA, data: bus.jal_addr};
    mdu_entry = '{valid: 1'b1, reg_idx: bus.mdu_reg, data: bus.mdu_data};
  end

  regfile_wq #(
    .DEPTH (DEPTH)
  ) u_wq (
    .clk         (clk),
    .reset       (reset),
    .push0       (jal_acc),
    .push0_entry (jal_entry),
    .push1       (mdu_push),
    .push1_entry (mdu_entry),
    .pop         (pop),
    .cancel      (wb_sel && !reset),
    .cancel_reg  (bus.wb_reg),
    .look_reg1   (bus.rd_reg1),
    .look_reg2   (bus.rd_reg2),
    .hit1        (hit1),
    .hit2        (hit2),
    .head        (head),
    .count       (q_cnt)
  );

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      NORMAL: begin
        if (pop) begin
          starve_d = '0;
        end else if (q_cnt != '0 && wb_sel) begin
          starve_d = starve_q + 1'b1;
          if (starve_d == SW'(STARVE_LIMIT)) state_d = STARVED;
        end
      end
      STARVED: begin
        if (pop) begin
          state_d  = NORMAL;
          starve_d = '0;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // A cancelled head still consumes its drain slot but leaves address/data untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (wb_sel) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= bus.wb_reg;
      rf_wdata_q <= bus.wb_data;
    end else if (pop && head.valid) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= head.reg_idx;
      rf_wdata_q <= head.data;
    end else begin
      rf_we_q    <= 1'b0;
    end
  end

  assign bus.mdu_ready   = mdu_rdy;
  assign bus.stall       = stall_c;
  assign bus.rd_pending1 = !reset && (bus.rd_reg1 != REG_ZERO) &&
                           (hit1 || (rf_we_q && rf_waddr_q == bus.rd_reg1));
  assign bus.rd_pending2 = !reset && (bus.rd_reg2 != REG_ZERO) &&
                           (hit2 || (rf_we_q && rf_waddr_q == bus.rd_reg2));
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.q_count     = q_cnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  regfile_write_arbiter_if #(.DEPTH(4)) bus ();

  regfile_write_arbiter #(
    .DEPTH        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want summary before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_we     = 1'b0;
    bus.wb_reg    = '0;
    bus.wb_data   = '0;
    bus.jal_valid = 1'b0;
    bus.jal_addr  = '0;
    bus.mdu_valid = 1'b0;
    bus.mdu_reg   = '0;
    bus.mdu_data  = '0;
    bus.rd_reg1   = '0;
    bus.rd_reg2   = '0;
  endtask

  task automatic mdu_push(input logic [4:0] r, input logic [31:0] d);
    bus.mdu_valid = 1'b1;
    bus.mdu_reg   = r;
    bus.mdu_data  = d;
    tick();
    bus.mdu_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    reset = 1'b1;
    bus.mdu_valid = 1'b1;
    bus.rd_reg1   = 5'd31;
    tick();
    tick();
    check("rst_mdu_ready", bus.mdu_ready, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_pending", bus.rd_pending1, 0);
    idle();
    reset = 1'b0;
    #1;
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rf_waddr", bus.rf_waddr, 0);
    check("rst_rf_wdata", bus.rf_wdata, 0);
    check("rst_q_count", bus.q_count, 0);

    // 1: JAL link write drains on the next free cycle
    bus.jal_valid = 1'b1;
    bus.jal_addr  = 32'h0040_0010;
    bus.rd_reg1   = 5'd31;
    tick();
    bus.jal_valid = 1'b0;
    check("jal_q1", bus.q_count, 1);
    check("jal_pend_q", bus.rd_pending1, 1);
    tick();
    check("jal_rf_we", bus.rf_we, 1);
    check("jal_rf_waddr", bus.rf_waddr, 31);
    check("jal_rf_wdata", bus.rf_wdata, 32'h0040_0010);
    check("jal_q0", bus.q_count, 0);
    check("jal_pend_rf", bus.rd_pending1, 1);
    tick();
    check("jal_idle_we", bus.rf_we, 0);
    check("jal_hold_addr", bus.rf_waddr, 31);
    check("jal_pend_done", bus.rd_pending1, 0);

    // 2: starvation under continuous WB
    idle();
    bus.wb_we     = 1'b1;
    bus.wb_reg    = 5'd8;
    bus.wb_data   = 32'h0000_aaaa;
    bus.rd_reg2   = 5'd9;
    bus.mdu_valid = 1'b1;
    bus.mdu_reg   = 5'd9;
    bus.mdu_data  = 32'h0000_1234;
    #1;
    check("st_mdu_ready", bus.mdu_ready, 1);
    tick();
    bus.mdu_valid = 1'b0;
    check("st_q1", bus.q_count, 1);
    check("st_wb_addr", bus.rf_waddr, 8);
    check("st_pend9", bus.rd_pending2, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("st_stall_%0d", i), bus.stall, (i == 8) ? 1 : 0);
    end
    check("st_held_q", bus.q_count, 1);
    bus.wb_we     = 1'b0;
    bus.jal_valid = 1'b1;
    bus.jal_addr  = 32'h0000_0bad;
    tick();
    bus.jal_valid = 1'b0;
    check("st_drain_we", bus.rf_we, 1);
    check("st_drain_addr", bus.rf_waddr, 9);
    check("st_drain_data", bus.rf_wdata, 32'h0000_1234);
    check("st_stall_drop", bus.stall, 0);
    check("st_jal_refused", bus.q_count, 0);
    tick();
    check("st_pend9_done", bus.rd_pending2, 0);

    // 3: WB to the same register cancels a queued MDU write
    idle();
    bus.wb_we   = 1'b1;
    bus.wb_reg  = 5'd8;
    bus.wb_data = 32'h0000_0001;
    mdu_push(5'd10, 32'd5);
    check("cn_q1", bus.q_count, 1);
    bus.wb_reg  = 5'd10;
    bus.wb_data = 32'd7;
    tick();
    check("cn_wb_addr", bus.rf_waddr, 10);
    check("cn_wb_data", bus.rf_wdata, 7);
    bus.wb_we   = 1'b0;
    bus.rd_reg1 = 5'd10;
    tick();
    check("cn_drain_we", bus.rf_we, 0);
    check("cn_q0", bus.q_count, 0);
    check("cn_final_data", bus.rf_wdata, 7);
    check("cn_pend10", bus.rd_pending1, 0);

    // 4: fill to DEPTH; JAL beats MDU for the last slot
    idle();
    bus.wb_we   = 1'b1;
    bus.wb_reg  = 5'd20;
    bus.wb_data = 32'h0000_0020;
    mdu_push(5'd11, 32'h11);
    mdu_push(5'd12, 32'h12);
    mdu_push(5'd13, 32'h13);
    check("fl_q3", bus.q_count, 3);
    check("fl_stall0", bus.stall, 0);
    bus.jal_valid = 1'b1;
    bus.jal_addr  = 32'h0000_0100;
    bus.mdu_valid = 1'b1;
    bus.mdu_reg   = 5'd14;
    bus.mdu_data  = 32'h14;
    #1;
    check("fl_mdu_ready0", bus.mdu_ready, 0);
    tick();
    bus.jal_valid = 1'b0;
    bus.mdu_valid = 1'b0;
    check("fl_q4", bus.q_count, 4);
    check("fl_stall1", bus.stall, 1);
    bus.wb_we = 1'b0;
    tick();
    check("fl_d1_addr", bus.rf_waddr, 11);
    check("fl_stall_rel", bus.stall, 0);
    tick();
    check("fl_d2_addr", bus.rf_waddr, 12);
    tick();
    check("fl_d3_addr", bus.rf_waddr, 13);
    tick();
    check("fl_d4_addr", bus.rf_waddr, 31);
    check("fl_d4_data", bus.rf_wdata, 32'h0000_0100);
    check("fl_q_empty", bus.q_count, 0);
    tick();

    // 5: reset mid-queue drops everything
    idle();
    bus.wb_we   = 1'b1;
    bus.wb_reg  = 5'd21;
    bus.wb_data = 32'h21;
    mdu_push(5'd1, 32'h1);
    mdu_push(5'd2, 32'h2);
    mdu_push(5'd3, 32'h3);
    check("rs_q3", bus.q_count, 3);
    bus.wb_we   = 1'b0;
    bus.rd_reg1 = 5'd1;
    bus.rd_reg2 = 5'd3;
    reset       = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rs_q0", bus.q_count, 0);
    check("rs_rf_we", bus.rf_we, 0);
    check("rs_pend1", bus.rd_pending1, 0);
    check("rs_pend2", bus.rd_pending2, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rs_no_write_%0d", i), bus.rf_we, 0);
    end

    // 6: writes to $0 are discarded
    idle();
    bus.wb_we     = 1'b1;
    bus.wb_reg    = 5'd0;
    bus.wb_data   = 32'h0000_dead;
    bus.mdu_valid = 1'b1;
    bus.mdu_reg   = 5'd0;
    bus.mdu_data  = 32'h0000_beef;
    #1;
    check("z_pend0", bus.rd_pending1, 0);
    tick();
    idle();
    check("z_q0", bus.q_count, 0);
    check("z_rf_we", bus.rf_we, 0);
    tick();
    check("z_rf_we2", bus.rf_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
